// File: rtl/alu_pkg.sv
// Shared opcode, sub-unit mode and FSM encodings for the sequential ALU core.
package alu_pkg;

  localparam logic [3:0] OP_ADD         = 4'd0;
  localparam logic [3:0] OP_SUB         = 4'd1;
  localparam logic [3:0] OP_MUL         = 4'd2;
  localparam logic [3:0] OP_DIV         = 4'd3;
  localparam logic [3:0] OP_AND         = 4'd4;
  localparam logic [3:0] OP_OR          = 4'd5;
  localparam logic [3:0] OP_XOR         = 4'd6;
  localparam logic [3:0] OP_NAND        = 4'd7;
  localparam logic [3:0] OP_NOR         = 4'd8;
  localparam logic [3:0] OP_NOT         = 4'd9;
  localparam logic [3:0] OP_MOD         = 4'd10;
  localparam logic [3:0] OP_SHL         = 4'd11;
  localparam logic [3:0] OP_SHR         = 4'd12;
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd13;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide/modulo by zero is resolved immediately, so only a nonzero divisor iterates.
  function automatic logic is_iter_op(input logic [3:0] op, input logic b_nonzero);
    return (op == OP_MUL) || (b_nonzero && ((op == OP_DIV) || (op == OP_MOD)));
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, one shared WIDTH+1 adder.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic             r_busy;
  logic             r_mode;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_x;
  logic [WIDTH:0]   w_y;
  logic             w_cin;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // MUL adds b when the multiplier LSB is set; DIV subtracts b from the shifted remainder.
  always_comb begin
    w_x   = {1'b0, r_acc};
    w_y   = '0;
    w_cin = 1'b0;
    if (r_mode == MODE_DIV) begin
      w_x   = {r_acc, r_q[WIDTH-1]};
      w_y   = {1'b1, ~r_b};
      w_cin = 1'b1;
    end else if (r_q[0]) begin
      w_y = {1'b0, r_b};
    end
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{(WIDTH+1){1'b0}}, w_cin};

  always_comb begin
    w_acc_nxt = w_sum[WIDTH:1];
    w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    if (r_mode == MODE_DIV) begin
      // Carry out of the WIDTH+1 adder means the trial subtraction did not borrow.
      if (w_sum[WIDTH+1]) begin
        w_acc_nxt = w_sum[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_x[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_mode <= MODE_MUL;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_b    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_mode <= i_mode;
      r_cnt  <= CW'(WIDTH - 1);
      r_acc  <= '0;
      r_q    <= i_a;
      r_b    <= i_b;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // The final step's values are offered combinationally so the caller can register them on that edge.
  assign o_done = r_busy && (r_cnt == '0);
  assign o_lo   = w_q_nxt;
  assign o_hi   = w_acc_nxt;

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith ops, iterative MUL/DIV/MOD, registered results and flags.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dbz,
  output logic             flag_err,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds valid and payload stable until that edge, ready never waits on valid.

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_z;
  logic             r_c;
  logic             r_v;
  logic             r_dbz;
  logic             r_err;

  logic             w_accept;
  logic             w_iter;
  logic             w_start;
  logic             w_b_big;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_sc_res;
  logic [WIDTH-1:0] w_sc_hi;
  logic             w_sc_c;
  logic             w_sc_v;
  logic             w_sc_dbz;
  logic             w_sc_err;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_it_res;
  logic [WIDTH-1:0] w_it_hi;
  logic             w_it_z;

  assign w_accept = in_valid && r_in_ready;
  assign w_iter   = is_iter_op(op, b != '0);
  assign w_start  = w_accept && w_iter;

  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = {1'b0, a} - {1'b0, b};
  assign w_b_big = (b >= WIDTH'(WIDTH));
  assign w_shl   = w_b_big ? '0 : (a << b[SHW-1:0]);
  assign w_shr   = w_b_big ? '0 : (a >> b[SHW-1:0]);

  always_comb begin
    w_sc_res = '0;
    w_sc_hi  = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    w_sc_dbz = 1'b0;
    w_sc_err = 1'b0;
    case (op)
      OP_ADD: begin
        w_sc_res = w_add[WIDTH-1:0];
        w_sc_c   = w_add[WIDTH];
        w_sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res = w_sub[WIDTH-1:0];
        w_sc_c   = w_sub[WIDTH];
        w_sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIV, OP_MOD: begin
        // Only reached here with b == 0; nonzero divisors go through the iterative unit.
        w_sc_res = '1;
        w_sc_hi  = a;
        w_sc_dbz = 1'b1;
      end
      OP_AND:  w_sc_res = a & b;
      OP_OR:   w_sc_res = a | b;
      OP_XOR:  w_sc_res = a ^ b;
      OP_NAND: w_sc_res = ~(a & b);
      OP_NOR:  w_sc_res = ~(a | b);
      OP_NOT:  w_sc_res = ~a;
      OP_SHL:  w_sc_res = w_shl;
      OP_SHR:  w_sc_res = w_shr;
      default: w_sc_err = (op >= OP_ILLEGAL_MIN);
    endcase
  end

  // Completion of an iterative op: MOD reports the remainder as the primary result.
  always_comb begin
    w_it_res = w_md_lo;
    w_it_hi  = w_md_hi;
    w_it_z   = (w_md_lo == '0);
    if (r_op == OP_MUL) begin
      w_it_z = (w_md_lo == '0) && (w_md_hi == '0);
    end else if (r_op == OP_MOD) begin
      w_it_res = w_md_hi;
      w_it_hi  = '0;
      w_it_z   = (w_md_hi == '0);
    end
  end

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_mode  ((op == OP_MUL) ? MODE_MUL : MODE_DIV),
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_md_done),
    .o_lo    (w_md_lo),
    .o_hi    (w_md_hi)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_op        <= OP_ADD;
      r_result    <= '0;
      r_result_hi <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_dbz       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op       <= op;
            r_in_ready <= 1'b0;
            if (w_iter) begin
              r_state <= ST_EXEC;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_sc_res;
              r_result_hi <= w_sc_hi;
              r_z         <= (w_sc_res == '0);
              r_c         <= w_sc_c;
              r_v         <= w_sc_v;
              r_dbz       <= w_sc_dbz;
              r_err       <= w_sc_err;
            end
          end
        end
        ST_EXEC: begin
          if (w_md_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_it_res;
            r_result_hi <= w_it_hi;
            r_z         <= w_it_z;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_dbz       <= 1'b0;
            r_err       <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign flag_z      = r_z;
  assign flag_c      = r_c;
  assign flag_v      = r_v;
  assign flag_dbz    = r_dbz;
  assign flag_err    = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: directed cases at WIDTH=8, then randomized handshake sweeps at WIDTH=8 and WIDTH=4.
module tb_alu_seq_core;
  import alu_pkg::*;

  logic clk;
  logic rst_n;

  logic       iv8, or8;
  logic [3:0] op8;
  logic [7:0] a8, b8;
  logic       ir8, ov8, z8, c8, v8, dbz8, err8;
  logic [7:0] res8, hi8;
  logic [1:0] st8;
  logic [4:0] fl8;

  logic       iv4, or4;
  logic [3:0] op4;
  logic [3:0] a4, b4;
  logic       ir4, ov4, z4, c4, v4, dbz4, err4;
  logic [3:0] res4, hi4;
  logic [1:0] st4;

  int checks;
  int errors;
  logic [20:0] exp_q[$];

  assign fl8 = {z8, c8, v8, dbz8, err8};

  alu_seq_core #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .result(res8), .result_hi(hi8),
    .flag_z(z8), .flag_c(c8), .flag_v(v8), .flag_dbz(dbz8), .flag_err(err8), .o_dbg_state(st8)
  );

  alu_seq_core #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op(op4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .result(res4), .result_hi(hi4),
    .flag_z(z4), .flag_c(c4), .flag_v(v4), .flag_dbz(dbz4), .flag_err(err4), .o_dbg_state(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result, high word and flags {z,c,v,dbz,err} from plain integer arithmetic.
  function automatic logic [20:0] model(input int w, input int op, input int a, input int b);
    int m, r, h, p, sa, sb, sr;
    bit z, c, v, dbz, err;
    m = (1 << w) - 1;
    r = 0; h = 0; p = 0; c = 0; v = 0; dbz = 0; err = 0;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    case (op)
      0: begin
        p = a + b; r = p & m; c = (p > m);
        sr = sa + sb; v = (sr >= (1 << (w - 1))) || (sr < -(1 << (w - 1)));
      end
      1: begin
        r = (a - b) & m; c = (a < b);
        sr = sa - sb; v = (sr >= (1 << (w - 1))) || (sr < -(1 << (w - 1)));
      end
      2: begin p = a * b; r = p & m; h = p >> w; end
      3, 10: begin
        if (b == 0) begin r = m; h = a; dbz = 1; end
        else if (op == 3) begin r = a / b; h = a % b; end
        else r = a % b;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = ~(a & b) & m;
      8: r = ~(a | b) & m;
      9: r = ~a & m;
      11: r = (b >= w) ? 0 : ((a << b) & m);
      12: r = (b >= w) ? 0 : (a >> b);
      default: err = 1;
    endcase
    z = (op == 2) ? (p == 0) : (r == 0);
    return {r[7:0], h[7:0], z, c, v, dbz, err};
  endfunction

  // driver tasks
  task automatic send8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input bit wait_out, output int lat, output bit ir_low);
    int guard;
    guard = 0; lat = 0; ir_low = 1;
    @(negedge clk);
    while (!ir8 && guard < 50) begin @(negedge clk); guard++; end
    check("accept_ready", 32'(ir8), 32'd1);
    op8 = o; a8 = x; b8 = y; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    if (wait_out) begin
      do begin
        @(negedge clk);
        lat++;
        if (ir8) ir_low = 0;
      end while (!ov8 && lat < 50);
      check("result_wait", 32'(ov8), 32'd1);
    end
  endtask

  task automatic take8();
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
  endtask

  task automatic set_in(input int w, input logic iv, input logic [3:0] o,
                        input logic [7:0] x, input logic [7:0] y, input logic ordy);
    if (w == 8) begin
      iv8 = iv; op8 = o; a8 = x; b8 = y; or8 = ordy;
    end else begin
      iv4 = iv; op4 = o; a4 = x[3:0]; b4 = y[3:0]; or4 = ordy;
    end
  endtask

  task automatic get_out(input int w, output logic ir, output logic ov, output logic [20:0] obs);
    if (w == 8) begin
      ir = ir8; ov = ov8; obs = {res8, hi8, z8, c8, v8, dbz8, err8};
    end else begin
      ir = ir4; ov = ov4; obs = {4'h0, res4, 4'h0, hi4, z4, c4, v4, dbz4, err4};
    end
  endtask

  // Random ops with random valid gaps and sink stalls; scoreboard pops in order on each sink transfer.
  task automatic sweep(input int w, input int n);
    int sent, got, cyc;
    bit pend, seen;
    logic cur_iv, cur_or, ir, ov;
    logic [3:0] cop;
    logic [7:0] ca, cb;
    logic [20:0] obs, e;
    sent = 0; got = 0; cyc = 0; pend = 0; cur_iv = 0;
    cop = '0; ca = '0; cb = '0;
    exp_q.delete();
    while (got < n && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (!pend) begin
        cur_iv = 1'b0;
        if (sent < n && $urandom_range(0, 2) != 0) begin
          cop = 4'($urandom_range(0, 15));
          ca  = 8'($urandom_range(0, (1 << w) - 1));
          cb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, w + 1))
                                            : 8'($urandom_range(0, (1 << w) - 1));
          cur_iv = 1'b1;
          pend = 1;
        end
      end
      cur_or = ($urandom_range(0, 3) != 0);
      set_in(w, cur_iv, cop, ca, cb, cur_or);
      #1;
      get_out(w, ir, ov, obs);
      if (cur_iv && ir) begin
        exp_q.push_back(model(w, int'(cop), int'(ca), int'(cb)));
        sent++;
        pend = 0;
      end
      if (ov && cur_or) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check($sformatf("sweep_w%0d_n%0d", w, got), 32'(obs), 32'(e));
        got++;
      end
    end
    check($sformatf("sweep_w%0d_count", w), 32'(got), 32'(n));
    check($sformatf("sweep_w%0d_left", w), 32'(exp_q.size()), 32'd0);
    seen = 0;
    set_in(w, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
    repeat (15) begin
      @(negedge clk);
      get_out(w, ir, ov, obs);
      if (ov) seen = 1;
    end
    check($sformatf("sweep_w%0d_no_extra", w), 32'(seen), 32'd0);
    set_in(w, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    int lat;
    bit irl;
    bit seen;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    iv8 = 0; or8 = 0; op8 = '0; a8 = '0; b8 = '0;
    iv4 = 0; or4 = 0; op4 = '0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'({ir8, ir4}), 32'b11);
    check("reset_valid", 32'({ov8, ov4}), 32'b00);
    check("reset_outs", 32'({res8, hi8, fl8}), 32'd0);
    rst_n = 1'b1;

    send8(OP_ADD, 8'd200, 8'd100, 1, lat, irl);
    check("add_latency", 32'(lat), 32'd1);
    check("add_result", 32'({res8, hi8}), 32'({8'd44, 8'd0}));
    check("add_flags", 32'(fl8), 32'b01000);
    take8();

    send8(OP_SUB, 8'h7F, 8'hFF, 1, lat, irl);
    check("sub_ovf_result", 32'(res8), 32'h80);
    check("sub_ovf_flags", 32'(fl8), 32'b01100);
    take8();

    send8(OP_SUB, 8'd5, 8'd5, 1, lat, irl);
    check("sub_zero_result", 32'(res8), 32'd0);
    check("sub_zero_flags", 32'(fl8), 32'b10000);
    take8();

    send8(OP_MUL, 8'd255, 8'd255, 1, lat, irl);
    check("mul_latency", 32'(lat), 32'd9);
    check("mul_ready_low", 32'(irl), 32'd1);
    check("mul_result", 32'({res8, hi8}), 32'h01FE);
    check("mul_flags", 32'(fl8), 32'b00000);
    take8();

    send8(OP_DIV, 8'd200, 8'd7, 1, lat, irl);
    check("div_latency", 32'(lat), 32'd9);
    check("div_result", 32'({res8, hi8}), 32'({8'd28, 8'd4}));
    take8();

    send8(OP_MOD, 8'd200, 8'd7, 1, lat, irl);
    check("mod_result", 32'({res8, hi8}), 32'({8'd4, 8'd0}));
    take8();

    send8(OP_DIV, 8'd9, 8'd0, 1, lat, irl);
    check("dbz_latency", 32'(lat), 32'd1);
    check("dbz_result", 32'({res8, hi8}), 32'h FF09);
    check("dbz_flags", 32'(fl8), 32'b00010);
    take8();

    // Sink stalls for five cycles while the source offers a new command.
    send8(OP_XOR, 8'hA5, 8'h0F, 1, lat, irl);
    op8 = OP_ADD; a8 = 8'd1; b8 = 8'd1; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_%0d", i), 32'({ov8, ir8, res8, hi8, fl8}),
            32'({1'b1, 1'b0, 8'hAA, 8'h00, 5'b00000}));
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_no_accept", 32'({ov8, ir8}), 32'b01);

    // Reset in the middle of a multiply.
    send8(OP_MUL, 8'hFF, 8'hFF, 0, lat, irl);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_state", 32'({ov8, ir8, res8, hi8, fl8}), 32'({1'b0, 1'b1, 21'd0}));
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) seen = 1;
    end
    check("midreset_no_stale", 32'(seen), 32'd0);

    sweep(8, 300);
    sweep(4, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
